// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-32 control unit: Moore FSM sequencing fetch/decode/execute/
// memory/write-back over a shared datapath, with memory ready handshake,
// wait watchdog and sticky fault state.
module multicycle_control_unit #(
   parameter bit          MEM_HANDSHAKE    = 1'b1,
   parameter int unsigned MAX_WAIT         = 15,
   parameter bit          ENABLE_IMM_LOGIC = 1'b1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [5:0] OpCode,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       BranchNE,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemToReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       JAL,
   output logic       ZeroExt,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       Fault,
   output logic [3:0] State
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_RWB    = 4'd7,
      S_EXEC_I = 4'd8,
      S_IWB    = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_FAULT  = 4'd12
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] wait_cnt, next_wait_cnt;
   logic [5:0]       op_q, next_op;
   logic             mem_done;
   logic             zero_ext_op;

   // State, wait counter and opcode latched in DECODE
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         op_q     <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
         op_q     <= next_op;
      end
   end

   // Next-state logic and Moore output decode
   always_comb begin
      next_state    = state;
      next_wait_cnt = '0;
      next_op       = op_q;
      mem_done      = !MEM_HANDSHAKE || MemReady;
      zero_ext_op   = (op_q == OP_ANDI) || (op_q == OP_ORI);
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      BranchNE      = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      MemToReg      = 1'b0;
      RegDst        = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      JAL           = 1'b0;
      ZeroExt       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = 2'b00;
      PCSource      = 2'b00;
      Fault         = 1'b0;
      State         = 4'd0;

      case (state)
         S_FETCH, S_MEMRD, S_MEMWR: begin
            if (mem_done) begin
               if (state == S_FETCH)      next_state = S_DECODE;
               else if (state == S_MEMRD) next_state = S_MEMWB;
               else                       next_state = S_FETCH;
            end else if (wait_cnt == WAIT_LAST) begin
               next_state = S_FAULT;
            end else begin
               next_wait_cnt = wait_cnt + CNT_W'(1);
            end
         end
         S_DECODE: begin
            next_op = OpCode;
            case (OpCode)
               OP_RTYPE:                next_state = S_EXEC_R;
               OP_LW, OP_SW:            next_state = S_MEMADR;
               OP_ADDI:                 next_state = S_EXEC_I;
               OP_ANDI, OP_ORI, OP_SLTI:
                  next_state = ENABLE_IMM_LOGIC ? S_EXEC_I : S_FAULT;
               OP_BEQ, OP_BNE:          next_state = S_BRANCH;
               OP_J, OP_JAL:            next_state = S_JUMP;
               default:                 next_state = S_FAULT;
            endcase
         end
         S_MEMADR: next_state = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_EXEC_R: next_state = S_RWB;
         S_EXEC_I: next_state = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
         S_FAULT:  next_state = S_FAULT;
         default:  next_state = S_FAULT;
      endcase

      if (!Reset) begin
         State = 4'(state);
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_done;
               PCWrite = mem_done;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemToReg = 1'b1;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_RWB: begin
               RegDst   = 1'b1;
               RegWrite = 1'b1;
            end
            S_EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUOp   = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
               ZeroExt = zero_ext_op;
            end
            S_IWB: begin
               RegWrite = 1'b1;
               ZeroExt  = zero_ext_op;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               BranchNE    = (op_q == OP_BNE);
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               JAL      = (op_q == OP_JAL);
               RegWrite = (op_q == OP_JAL);
            end
            S_FAULT: Fault = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference model builds
// per-cycle expected control words into a scoreboard; a negedge monitor
// compares. dut 0: handshake on, imm logic on; dut 1: no handshake, imm off.
module tb_multicycle_control_unit;

   localparam int unsigned MW0 = 15;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
   localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;

   localparam logic [12:0] F_PCW = 13'h1000, F_PCWC = 13'h0800, F_BNE = 13'h0400;
   localparam logic [12:0] F_IORD = 13'h0200, F_IRW = 13'h0100, F_MRD = 13'h0080;
   localparam logic [12:0] F_MWR = 13'h0040, F_M2R = 13'h0020, F_RDST = 13'h0010;
   localparam logic [12:0] F_RWR = 13'h0008, F_ASA = 13'h0004, F_JAL = 13'h0002;
   localparam logic [12:0] F_ZEXT = 13'h0001;

   typedef logic [23:0] exp_t;
   typedef struct packed {
      logic which;
      exp_t e;
   } sb_t;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic       r0, r1, m0, m1;
   logic [5:0] o0, o1;

   logic pcw [2], pcwc [2], bneo [2], iord [2], irw [2], mrd [2], mwr [2];
   logic m2r [2], rdst [2], rwr [2], asa [2], jalo [2], zext [2], flt [2];
   logic [1:0] asb [2], aop [2], pcs [2];
   logic [3:0] st [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      multicycle_control_unit #(
         .MEM_HANDSHAKE   (g == 0),
         .MAX_WAIT        (MW0),
         .ENABLE_IMM_LOGIC(g == 0)
      ) dut (
         .Clock      (Clock),
         .Reset      (g == 0 ? r0 : r1),
         .OpCode     (g == 0 ? o0 : o1),
         .MemReady   (g == 0 ? m0 : m1),
         .PCWrite    (pcw[g]),
         .PCWriteCond(pcwc[g]),
         .BranchNE   (bneo[g]),
         .IorD       (iord[g]),
         .IRWrite    (irw[g]),
         .MemRead    (mrd[g]),
         .MemWrite   (mwr[g]),
         .MemToReg   (m2r[g]),
         .RegDst     (rdst[g]),
         .RegWrite   (rwr[g]),
         .ALUSrcA    (asa[g]),
         .JAL        (jalo[g]),
         .ZeroExt    (zext[g]),
         .ALUSrcB    (asb[g]),
         .ALUOp      (aop[g]),
         .PCSource   (pcs[g]),
         .Fault      (flt[g]),
         .State      (st[g])
      );
   end

   sb_t sb[$];
   int  checks = 0;
   int  passed = 0;

   function automatic exp_t mk(input logic [12:0] f, input logic [1:0] srcb,
                               input logic [1:0] aluop, input logic [1:0] pcsrc,
                               input logic fault, input logic [3:0] s);
      return {f, srcb, aluop, pcsrc, fault, s};
   endfunction

   function automatic exp_t actual(input logic w);
      int i;
      i = w ? 1 : 0;
      return {pcw[i], pcwc[i], bneo[i], iord[i], irw[i], mrd[i], mwr[i], m2r[i],
              rdst[i], rwr[i], asa[i], jalo[i], zext[i], asb[i], aop[i], pcs[i],
              flt[i], st[i]};
   endfunction

   // Scoreboard monitor: one expected control word per cycle
   sb_t  mon_item;
   exp_t mon_act;
   always @(negedge Clock) begin
      if (sb.size() != 0) begin
         mon_item = sb.pop_front();
         mon_act  = actual(mon_item.which);
         checks++;
         if (mon_act === mon_item.e) passed++;
         else $display("FAIL dut%0d ctl(exp state %0d): got %h expected %h",
                       mon_item.which, mon_item.e[3:0], mon_act, mon_item.e);
      end
   end

   // Immediate check of the settled outputs right after a clock edge
   task automatic check_now(input int w, input exp_t e, input string what);
      exp_t a;
      a = actual(w != 0);
      checks++;
      if (a === e) passed++;
      else $display("FAIL dut%0d %s: got %h expected %h", w, what, a, e);
   endtask

   // Drive one cycle of inputs and queue the expected output word
   task automatic cyc(input int w, input logic r, input logic [5:0] o,
                      input logic m, input exp_t e);
      sb_t it;
      if (w == 0) begin r0 = r; o0 = o; m0 = m; end
      else        begin r1 = r; o1 = o; m1 = m; end
      it.which = (w != 0);
      it.e     = e;
      sb.push_back(it);
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [5:0] junk();
      return 6'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic reset_cycles(input int w, input int n);
      for (int i = 0; i < n; i++) cyc(w, 1'b1, junk(), rb(), '0);
   endtask

   // Sticky fault for a few cycles, then recover by reset
   task automatic fault_out(input int w);
      int n;
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) cyc(w, 1'b0, junk(), rb(), mk('0, 2'b00, 2'b00, 2'b00, 1'b1, 4'd12));
      reset_cycles(w, $urandom_range(1, 2));
   endtask

   // A memory access: waits cycles with ready low, then one ready cycle.
   // res: 0 done, 1 watchdog fault, 2 aborted at abort_k for a reset.
   task automatic access(input int w, input logic [3:0] s, input logic [1:0] srcb,
                         input logic [12:0] fw, input logic [12:0] fd,
                         input int waits, input int abort_k, output int res);
      res = 0;
      if (w == 1) begin
         cyc(w, 1'b0, junk(), rb(), mk(fd, srcb, 2'b00, 2'b00, 1'b0, s));
         return;
      end
      for (int k = 0; k <= waits; k++) begin
         if (k == abort_k) begin
            res = 2;
            return;
         end
         if (k == waits) begin
            cyc(w, 1'b0, junk(), 1'b1, mk(fd, srcb, 2'b00, 2'b00, 1'b0, s));
         end else begin
            cyc(w, 1'b0, junk(), 1'b0, mk(fw, srcb, 2'b00, 2'b00, 1'b0, s));
            if (k == int'(MW0) - 1) begin
               check_now(w, mk('0, 2'b00, 2'b00, 2'b00, 1'b1, 4'd12), "expired wait");
               res = 1;
               return;
            end
         end
      end
   endtask

   task automatic finish_access(input int w, input int res);
      if (res == 1) fault_out(w);
      else if (res == 2) reset_cycles(w, $urandom_range(1, 2));
   endtask

   // Whole-instruction reference model
   task automatic do_instr(input int w, input logic [5:0] o, input int wf,
                           input int wm, input int abort_k);
      int         res;
      logic       legal, immlog, zx;
      logic [12:0] zf;
      access(w, 4'd0, 2'b01, F_MRD, F_MRD | F_IRW | F_PCW, wf, -1, res);
      if (res != 0) begin
         finish_access(w, res);
         return;
      end
      cyc(w, 1'b0, o, rb(), mk('0, 2'b11, 2'b00, 2'b00, 1'b0, 4'd1));
      immlog = (o == OP_ANDI) || (o == OP_ORI) || (o == OP_SLTI);
      legal  = (o == OP_R) || (o == OP_LW) || (o == OP_SW) || (o == OP_ADDI) ||
               (immlog && w == 0) || (o == OP_BEQ) || (o == OP_BNE) ||
               (o == OP_J) || (o == OP_JAL);
      if (!legal) begin
         fault_out(w);
         return;
      end
      zx = (o == OP_ANDI) || (o == OP_ORI);
      zf = zx ? F_ZEXT : 13'h0;
      if (o == OP_R) begin
         cyc(w, 1'b0, junk(), rb(), mk(F_ASA, 2'b00, 2'b10, 2'b00, 1'b0, 4'd6));
         cyc(w, 1'b0, junk(), rb(), mk(F_RDST | F_RWR, 2'b00, 2'b00, 2'b00, 1'b0, 4'd7));
      end else if (o == OP_LW || o == OP_SW) begin
         cyc(w, 1'b0, junk(), rb(), mk(F_ASA, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2));
         if (o == OP_LW) begin
            access(w, 4'd3, 2'b00, F_MRD | F_IORD, F_MRD | F_IORD, wm, abort_k, res);
            if (res == 0) cyc(w, 1'b0, junk(), rb(), mk(F_RWR | F_M2R, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4));
         end else begin
            access(w, 4'd5, 2'b00, F_MWR | F_IORD, F_MWR | F_IORD, wm, abort_k, res);
         end
         finish_access(w, res);
      end else if (immlog || o == OP_ADDI) begin
         cyc(w, 1'b0, junk(), rb(), mk(F_ASA | zf, 2'b10, (o == OP_ADDI) ? 2'b00 : 2'b11, 2'b00, 1'b0, 4'd8));
         cyc(w, 1'b0, junk(), rb(), mk(F_RWR | zf, 2'b00, 2'b00, 2'b00, 1'b0, 4'd9));
      end else if (o == OP_BEQ || o == OP_BNE) begin
         cyc(w, 1'b0, junk(), rb(), mk(F_ASA | F_PCWC | ((o == OP_BNE) ? F_BNE : 13'h0),
                                       2'b00, 2'b01, 2'b01, 1'b0, 4'd10));
      end else begin
         cyc(w, 1'b0, junk(), rb(), mk(F_PCW | ((o == OP_JAL) ? (F_JAL | F_RWR) : 13'h0),
                                       2'b00, 2'b00, 2'b10, 1'b0, 4'd11));
      end
   endtask

   function automatic int rnd_wait();
      int r;
      r = $urandom_range(0, 99);
      if (r < 65) return 0;
      if (r < 92) return $urandom_range(1, 5);
      return $urandom_range(13, 17);
   endfunction

   task automatic random_run(input int w, input int n);
      logic [5:0] ops [14];
      int wm, ab;
      ops = '{OP_R, OP_LW, OP_SW, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_BEQ,
              OP_BNE, OP_J, OP_JAL, 6'b111111, 6'b000001, 6'b100000};
      for (int i = 0; i < n; i++) begin
         wm = rnd_wait();
         ab = ($urandom_range(0, 19) == 0 && wm > 0) ? $urandom_range(0, wm - 1) : -1;
         do_instr(w, ops[$urandom_range(0, 13)], rnd_wait(), wm, ab);
      end
   endtask

   initial begin
      r0 = 1'b1; r1 = 1'b1; o0 = '0; o1 = '0; m0 = 1'b0; m1 = 1'b0;
      @(posedge Clock);
      #1;

      reset_cycles(0, 2);
      check_now(0, '0, "reset state");
      do_instr(0, OP_LW,   0, 0,   -1);
      do_instr(0, OP_R,    0, 0,   -1);
      do_instr(0, OP_BEQ,  0, 0,   -1);
      do_instr(0, OP_BNE,  0, 0,   -1);
      do_instr(0, OP_JAL,  0, 0,   -1);
      do_instr(0, OP_ANDI, 0, 0,   -1);
      do_instr(0, OP_SW,   0, 3,   -1);
      do_instr(0, OP_SW,   0, 100, -1);
      do_instr(0, OP_LW,   0, 10,  2);
      do_instr(0, OP_LW,   14, 14, -1);
      do_instr(0, OP_ADDI, 15, 0,  -1);
      do_instr(0, 6'b111111, 0, 0, -1);
      random_run(0, 150);
      r0 = 1'b1;

      reset_cycles(1, 2);
      do_instr(1, OP_ANDI, 0, 0, -1);
      do_instr(1, OP_ORI,  0, 0, -1);
      do_instr(1, OP_SLTI, 0, 0, -1);
      do_instr(1, OP_ADDI, 0, 0, -1);
      do_instr(1, OP_LW,   5, 5, -1);
      do_instr(1, OP_SW,   5, 5, -1);
      random_run(1, 60);

      @(negedge Clock);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle MIPS-32 control decoder: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back cycles over a shared datapath and a single memory port. It sits between the instruction register (opcode source) and the multicycle datapath muxes, register file, ALU control and memory. It adds a ready handshake with a wait watchdog, bne, the andi/ori/slti immediates, and a sticky fault state.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait for MemReady; 0 = memory completes in one cycle, MemReady ignored
- MAX_WAIT, 15: wait cycles allowed per memory access before fault (1..255)
- ENABLE_IMM_LOGIC, 1: 0 = andi/ori/slti decode as illegal
- Clock  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high
- OpCode  in  6  Instruction[31:26] from the instruction register
- MemReady  in  1  memory access complete this cycle
- PCWrite, PCWriteCond, BranchNE, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, ALUSrcA, JAL, ZeroExt  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct field, 11 immediate op from OpCode
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- Fault  out  1  sticky: illegal opcode or memory timeout
- State  out  4  current state encoding, for debug

## Operation
- States: FETCH(0) DECODE(1) MEMADR(2) MEMRD(3) MEMWB(4) MEMWR(5) EXEC_R(6) RWB(7) EXEC_I(8) IWB(9) BRANCH(10) JUMP(11) FAULT(12).
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=1 only in the completing cycle (MemReady=1, or always when MEM_HANDSHAKE=0). Then go to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Dispatch on OpCode:
  - 000000 -> EXEC_R
  - 100011/101011 -> MEMADR
  - 001000 -> EXEC_I
  - 001100/001101/001010 -> EXEC_I (only when ENABLE_IMM_LOGIC=1)
  - 000100/000101 -> BRANCH
  - 000010/000011 -> JUMP
  - any other opcode -> FAULT
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10. RWB: RegDst=1, RegWrite=1, MemToReg=0.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. addi: ALUOp=00. andi/ori/slti: ALUOp=11. ZeroExt=1 for andi/ori only. IWB: RegDst=0, RegWrite=1. ZeroExt is held through IWB.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD on lw, MEMWR on sw.
- MEMRD: MemRead=1, IorD=1; on completion -> MEMWB. MEMWB: RegWrite=1, MemToReg=1, RegDst=0.
- MEMWR: MemWrite=1, IorD=1; on completion -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=1 for bne.
- JUMP: PCWrite=1, PCSource=10. For jal, also JAL=1 and RegWrite=1 (datapath writes PC+4 to $31).
- RWB, IWB, MEMWB, BRANCH and JUMP all return to FETCH.
- Wait counter (8 bit): clears on entry to FETCH/MEMRD/MEMWR and increments each waiting cycle. An access still incomplete after MAX_WAIT waiting cycles -> FAULT, with no strobe issued.
- FAULT: all controls 0, Fault=1. Exit only by Reset.
- Every control not listed for a state is 0.

## Timing
- Outputs are pure decode of State; only IRWrite/PCWrite in FETCH are additionally gated by MemReady.
- Reset in any cycle, including mid-wait or in FAULT: next state FETCH, counter 0, Fault=0. While Reset is high, all outputs are forced 0 and State=0.
- Cycles per instruction with zero memory wait: beq/bne/j/jal 3; R/I-type 4; sw 4; lw 5. Each waiting cycle adds 1 to FETCH/MEMRD/MEMWR.
- MemReady outside a memory state is ignored.
- MemReady on the MAX_WAIT-th waiting cycle completes normally; the fault is taken only on the following cycle.
- OpCode is sampled only in DECODE; changes elsewhere have no effect.

## Test plan
- Reset held 2 cycles, then lw (100011), MemReady=1 always -> states 0,1,2,3,4,0; RegWrite=MemToReg=1 only in state 4; IRWrite exactly 1 cycle.
- R-type then beq (000100) then bne (000101), no wait -> EXEC_R ALUOp=10, RWB RegDst=1; BRANCH ALUOp=01, PCWriteCond=1, BranchNE=0 then 1.
- jal (000011) -> JUMP: PCWrite=1, PCSource=10, JAL=1, RegWrite=1; back to FETCH after 3 cycles total.
- andi (001100) -> EXEC_I ALUOp=11, ZeroExt=1; rerun with ENABLE_IMM_LOGIC=0 -> FAULT, Fault=1, held until Reset.
- sw with MemReady low 3 cycles then high (MAX_WAIT=15) -> MEMWR held 4 cycles, MemWrite high throughout, no fault; MemReady never high -> FAULT after 15 waiting cycles.
- Reset asserted during MEMRD wait -> next cycle State=0, all outputs 0, Fault=0; normal fetch resumes.
